mem_arbiter: RTL and testbench

//  Sequences the two MEM_REQUIRE slots from the dual-issue execute stage onto one data-memory port.
//  - Slot 0 is always served before slot 1 (program order).
//  - Non-memory slots pass through to writeback.
//  - Stalls the front end while a memory access is outstanding.
//  - Sits between execute and writeback; single owner of the dmem port.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arb_slot.sv | 28 ++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the dual-slot data-memory arbiter.
// MEM_ARB_ST_LD_FWD_EN (see mem_arbiter.sv) enables slot0-store to slot1-load forwarding.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(BE_W);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE
    } arb_state_e;

    typedef struct packed {
        logic              mem_en;
        logic              mem_we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_access_t;

    typedef struct packed {
        mem_access_t       acc;
        logic [DATA_W-1:0] result;
    } mem_require_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFS_W], OFS_W'(0)};
    endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// Holds one captured execute slot: its memory access and its writeback data.
module mem_arb_slot
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  mem_require_t      cap_req,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output mem_access_t       acc,
    output logic [DATA_W-1:0] data
);

    // Capture seeds data with the ALU result; a load return overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            data <= '0;
        end else if (capture) begin
            acc  <= cap_req.acc;
            data <= cap_req.result;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the two execute slots onto the single dmem port, slot 0 first.
// Optional `MEM_ARB_ST_LD_FWD_EN: forward a full-word slot0 store to a same-address slot1 load.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  mem_require_t [1:0]     mem_require,
    output logic                   stall,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [ADDR_W-1:0]      dmem_addr,
    output logic [DATA_W-1:0]      dmem_wdata,
    output logic [BE_W-1:0]        dmem_be,
    input  logic                   dmem_ready,
    input  logic                   dmem_rvalid,
    input  logic [DATA_W-1:0]      dmem_rdata,
    output logic [1:0]             wb_valid,
    output logic [1:0][DATA_W-1:0] wb_data
);

    arb_state_e        state, state_n;
    logic              abort, abort_n;
    logic              capture, s0_wr, s1_wr, fwd_hit;
    logic [DATA_W-1:0] s1_wr_data, s0_data, s1_data;
    mem_access_t       s0, s1, req_acc;
    logic              stall_d, req_d;
    logic [1:0]        wb_valid_d;

    mem_arb_slot u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .cap_req (mem_require[0]),
        .wr_en   (s0_wr),
        .wr_data (dmem_rdata),
        .acc     (s0),
        .data    (s0_data)
    );

    mem_arb_slot u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .cap_req (mem_require[1]),
        .wr_en   (s1_wr),
        .wr_data (s1_wr_data),
        .acc     (s1),
        .data    (s1_data)
    );

`ifdef MEM_ARB_ST_LD_FWD_EN
    assign fwd_hit = s0.mem_en && s0.mem_we && s1.mem_en && !s1.mem_we &&
                     (word_align(s0.addr) == word_align(s1.addr)) && (&s0.be);
`else
    assign fwd_hit = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            abort      <= 1'b0;
            stall      <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            wb_valid   <= '0;
            wb_data    <= '0;
        end else begin
            state    <= state_n;
            abort    <= abort_n;
            stall    <= stall_d;
            dmem_req <= req_d;
            wb_valid <= wb_valid_d;
            if (req_d) begin
                dmem_we    <= req_acc.mem_we;
                dmem_addr  <= word_align(req_acc.addr);
                dmem_wdata <= req_acc.wdata;
                dmem_be    <= req_acc.be;
            end
            if (state == DONE) begin
                wb_data <= {s1_data, s0_data};
            end
        end
    end

    // Next state and slot update strobes.
    always_comb begin
        state_n    = state;
        abort_n    = abort;
        capture    = 1'b0;
        s0_wr      = 1'b0;
        s1_wr      = 1'b0;
        s1_wr_data = dmem_rdata;
        case (state)
            IDLE, DONE: begin
                abort_n = 1'b0;
                state_n = IDLE;
                if (in_valid && !flush) begin
                    capture = 1'b1;
                    state_n = mem_require[0].acc.mem_en ? REQ0 :
                              mem_require[1].acc.mem_en ? REQ1 : DONE;
                end
            end
            REQ0: begin
                // A request accepted in the flush cycle still owes a response.
                if (dmem_ready) begin
                    state_n = WAIT0;
                    abort_n = flush;
                end else if (flush) begin
                    state_n = IDLE;
                end
            end
            WAIT0: begin
                if (dmem_rvalid) begin
                    abort_n = 1'b0;
                    if (abort || flush) begin
                        state_n = IDLE;
                    end else begin
                        s0_wr = !s0.mem_we;
                        if (fwd_hit) begin
                            s1_wr      = 1'b1;
                            s1_wr_data = s0.wdata;
                            state_n    = DONE;
                        end else begin
                            state_n = s1.mem_en ? REQ1 : DONE;
                        end
                    end
                end else if (flush) begin
                    abort_n = 1'b1;
                end
            end
            REQ1: begin
                if (dmem_ready) begin
                    state_n = WAIT1;
                    abort_n = flush;
                end else if (flush) begin
                    state_n = IDLE;
                end
            end
            WAIT1: begin
                if (dmem_rvalid) begin
                    abort_n = 1'b0;
                    if (abort || flush) begin
                        state_n = IDLE;
                    end else begin
                        s1_wr   = !s1.mem_we;
                        state_n = DONE;
                    end
                end else if (flush) begin
                    abort_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output next values; the request source is the input pair on the capture cycle.
    always_comb begin
        stall_d    = state_n inside {REQ0, WAIT0, REQ1, WAIT1};
        req_d      = (state_n == REQ0) || (state_n == REQ1);
        wb_valid_d = {2{(state == DONE) && !flush}};
        if (state_n == REQ1) begin
            req_acc = capture ? mem_require[1].acc : s1;
        end else begin
            req_acc = capture ? mem_require[0].acc : s0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed cases plus a randomized pair stream
// checked against a word-memory reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, flush, in_valid;
    mem_require_t [1:0]     mem_require;
    logic                   stall, dmem_req, dmem_we;
    logic [ADDR_W-1:0]      dmem_addr;
    logic [DATA_W-1:0]      dmem_wdata;
    logic [BE_W-1:0]        dmem_be;
    logic                   dmem_ready, dmem_rvalid;
    logic [DATA_W-1:0]      dmem_rdata;
    logic [1:0]             wb_valid;
    logic [1:0][DATA_W-1:0] wb_data;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .mem_require(mem_require), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_exp_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        int          hs;
    } wb_exp_t;

    int total = 0, bad = 0;
    req_exp_t req_q[$];
    wb_exp_t  wb_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] sim_mem [logic [31:0]];
    int exp_hs_total = 0, hs_count = 0;
    int force_dly = -1, force_rsp = -1, last_wait = 0;
    bit inj_rvalid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] sim_rd(input logic [31:0] a);
        return sim_mem.exists(a) ? sim_mem[a] : mem_default(a);
    endfunction

    function automatic mem_require_t mk(input logic en, input logic we, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] be,
                                        input logic [31:0] res);
        mem_require_t s;
        s.acc.mem_en = en; s.acc.mem_we = we; s.acc.addr = a;
        s.acc.wdata = wd; s.acc.be = be; s.result = res;
        return s;
    endfunction

    function automatic bit fwd_case(input mem_require_t a, input mem_require_t b);
`ifdef MEM_ARB_ST_LD_FWD_EN
        return a.acc.mem_en && a.acc.mem_we && b.acc.mem_en && !b.acc.mem_we &&
               a.acc.addr == b.acc.addr && a.acc.be == 4'hF;
`else
        return (a.acc.mem_en && 1'b0) || (b.acc.mem_en && 1'b0);
`endif
    endfunction

    // Reference: each memory slot is one access, in program order, on a word memory.
    task automatic ref_slot(input mem_require_t s, output logic [31:0] d);
        req_exp_t r;
        d = s.result;
        if (s.acc.mem_en) begin
            r.we = s.acc.mem_we; r.addr = s.acc.addr; r.wdata = s.acc.wdata; r.be = s.acc.be;
            req_q.push_back(r);
            exp_hs_total++;
            if (s.acc.mem_we) ref_mem[s.acc.addr] = merge(ref_rd(s.acc.addr), s.acc.wdata, s.acc.be);
            else d = ref_rd(s.acc.addr);
        end
    endtask

    // Call at a negedge; issues the pair once the arbiter can capture it.
    task automatic send_pair(input mem_require_t a, input mem_require_t b, input bit expect_wb);
        int guard = 0;
        wb_exp_t e;
        while (stall) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 1, 0);
                return;
            end
        end
        in_valid = 1'b1;
        mem_require[0] = a;
        mem_require[1] = b;
        if (expect_wb) begin
            ref_slot(a, e.d0);
            if (fwd_case(a, b)) e.d1 = a.acc.wdata;
            else ref_slot(b, e.d1);
            e.hs = exp_hs_total;
            wb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (stall || wb_q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                chk("idle_timeout", 1, 0);
                return;
            end
        end
        @(negedge clk);
    endtask

    // Memory responder: random ready delay, one outstanding access, random response latency.
    initial begin : responder
        int rdy_dly = -1, rsp_dly = 0, wait_cyc = 0;
        bit hs_pend = 1'b0, rsp_pend = 1'b0;
        logic hs_we;
        logic [31:0] hs_addr, hs_wdata, hold_addr, rsp_data;
        logic [3:0] hs_be;
        req_exp_t r;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (hs_pend) begin
                hs_pend = 1'b0;
                hs_count++;
                last_wait = wait_cyc;
                if (req_q.size() == 0) begin
                    chk("req_unexpected", {hs_we, hs_addr}, 0);
                end else begin
                    r = req_q.pop_front();
                    chk("req_we", hs_we, r.we);
                    chk("req_addr", hs_addr, r.addr);
                    if (r.we) begin
                        chk("req_wdata", hs_wdata, r.wdata);
                        chk("req_be", hs_be, r.be);
                    end
                end
                if (hs_we) begin
                    sim_mem[hs_addr] = merge(sim_rd(hs_addr), hs_wdata, hs_be);
                    rsp_data = '0;
                end else begin
                    rsp_data = sim_rd(hs_addr);
                end
                rsp_pend = 1'b1;
                rsp_dly = (force_rsp >= 0) ? force_rsp : int'($urandom_range(0, 2));
            end
            dmem_ready = 1'b0;
            dmem_rvalid = 1'b0;
            if (inj_rvalid) begin
                dmem_rvalid = 1'b1;
                dmem_rdata = 32'hBAD0_BAD0;
                inj_rvalid = 1'b0;
            end else if (rsp_pend) begin
                if (rsp_dly == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = rsp_data;
                    rsp_pend = 1'b0;
                end else begin
                    rsp_dly--;
                end
            end else if (dmem_req) begin
                if (rdy_dly < 0) begin
                    rdy_dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
                    wait_cyc = 0;
                    hold_addr = dmem_addr;
                end else begin
                    chk("req_stable", dmem_addr, hold_addr);
                end
                if (rdy_dly == 0) begin
                    dmem_ready = 1'b1;
                    hs_pend = 1'b1;
                    hs_we = dmem_we; hs_addr = dmem_addr; hs_wdata = dmem_wdata; hs_be = dmem_be;
                    rdy_dly = -1;
                end else begin
                    rdy_dly--;
                    wait_cyc++;
                end
            end else begin
                rdy_dly = -1;
            end
        end
    end

    // Writeback monitor.
    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid != 2'b00) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", wb_valid, 0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_valid", wb_valid, 2'b11);
                    chk("wb_data0", wb_data[0], e.d0);
                    chk("wb_data1", wb_data[1], e.d1);
                    chk("wb_hs_count", hs_count, e.hs);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : main
        int hs0, req_seen, wb_seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_require = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_dmem_be", dmem_be, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Two ALU ops: writeback two cycles after the issue cycle, no stall.
        send_pair(mk(0, 0, 0, 0, 0, 32'h11), mk(0, 0, 0, 0, 0, 32'h22), 1'b1);
        chk("alu_stall_n1", stall, 0);
        chk("alu_wb_early", wb_valid, 0);
        @(negedge clk);
        chk("alu_wb_latency", wb_valid, 2'b11);
        chk("alu_wb_data", wb_data, {32'h22, 32'h11});
        chk("alu_stall_n2", stall, 0);

        // Slot0 load with a 3-cycle ready delay.
        sim_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        force_dly = 3;
        send_pair(mk(1, 0, 32'h100, 0, 4'hF, 32'h77), mk(0, 0, 0, 0, 0, 32'h33), 1'b1);
        wait_idle();
        chk("ld_ready_wait", last_wait, 3);
        force_dly = -1;

        // Store then load to the neighbouring word.
        hs0 = hs_count;
        send_pair(mk(1, 1, 32'h200, 32'hA5A5_A5A5, 4'hF, 0), mk(1, 0, 32'h204, 0, 4'hF, 0), 1'b1);
        wait_idle();
        chk("st_ld_handshakes", hs_count - hs0, 2);

        // Store then load to the same word.
        hs0 = hs_count;
        send_pair(mk(1, 1, 32'h300, 32'h1234_5678, 4'hF, 0), mk(1, 0, 32'h300, 0, 4'hF, 0), 1'b1);
        wait_idle();
`ifdef MEM_ARB_ST_LD_FWD_EN
        chk("fwd_handshakes", hs_count - hs0, 1);
`else
        chk("fwd_handshakes", hs_count - hs0, 2);
`endif

        // Flush while slot0's load is outstanding; slot1 load must never be requested.
        hs0 = hs_count;
        force_dly = 0;
        force_rsp = 3;
        req_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, be: 4'hF});
        exp_hs_total++;
        send_pair(mk(1, 0, 32'h400, 0, 4'hF, 0), mk(1, 0, 32'h404, 0, 4'hF, 0), 1'b0);
        @(negedge clk);
        chk("flush_in_wait0", stall, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_seen = 0; wb_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (dmem_req) req_seen++;
            if (wb_valid != 2'b00) wb_seen++;
        end
        chk("flush_no_slot1_req", req_seen, 0);
        chk("flush_no_wb", wb_seen, 0);
        chk("flush_stall_clear", stall, 0);
        chk("flush_handshakes", hs_count - hs0, 1);
        force_dly = -1;
        force_rsp = -1;

        // Reset while slot1 is requesting; a stray response afterwards is ignored.
        hs0 = hs_count;
        force_dly = 5;
        send_pair(mk(0, 0, 0, 0, 0, 32'h55), mk(1, 0, 32'h500, 0, 4'hF, 0), 1'b0);
        chk("rst_in_req1_req", dmem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_dropped", dmem_req, 0);
        chk("rst_stall_dropped", stall, 0);
        rst = 1'b0;
        inj_rvalid = 1'b1;
        req_seen = 0; wb_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (dmem_req) req_seen++;
            if (wb_valid != 2'b00) wb_seen++;
        end
        chk("rst_late_rvalid_req", req_seen, 0);
        chk("rst_late_rvalid_wb", wb_seen, 0);
        chk("rst_handshakes", hs_count - hs0, 0);
        force_dly = -1;

        // Random pair stream, issued back to back.
        for (int i = 0; i < 60; i++) begin
            mem_require_t s[2];
            for (int k = 0; k < 2; k++) begin
                s[k] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom(),
                          ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 15)),
                          $urandom());
            end
            if ($urandom_range(0, 3) == 0) begin
                s[1].acc.mem_en = 1'b1; s[1].acc.mem_we = 1'b0; s[1].acc.addr = s[0].acc.addr;
            end
            send_pair(s[0], s[1], 1'b1);
        end
        wait_idle();

        chk("final_handshakes", hs_count, exp_hs_total);
        chk("final_wb_queue", wb_q.size(), 0);
        chk("final_req_queue", req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
